step_sequence_ctrl: RTL and testbench
=====================================

Name: step_sequence_ctrl

Overview:
- Controller that sits directly around the non-recycling counter. It drives that counter's clear input and consumes its saturated/done output.
- On start, it restarts the counter once per step and waits for the counter to saturate. It then advances a step index and repeats for NUM_STEPS steps before signalling completion.
- A watchdog flags a counter that never saturates.

Parameters:
- NUM_STEPS, 5, number of counter runs per sequence (1..2^STEP_W).
- STEP_W, 3, width of step index.
- CLR_CYCLES, 2, cycles cnt_clr is held high in RESTART (>=1).
- TIMEOUT, 200, max cycles allowed in WAIT_DONE before error (>=2).
- WD_W, 8, watchdog counter width (2^WD_W > TIMEOUT).

Ports:
- clk  in  1  system clock, rising edge.
- clrn  in  1  asynchronous active-low reset.
- start  in  1  begin sequence; sampled only in IDLE.
- abort  in  1  synchronous cancel; highest priority after reset.
- cnt_done  in  1  saturated/done level from the non-recycling counter; stays high until that counter is cleared.
- cnt_clr  out  1  active-high clear to the non-recycling counter.
- step  out  STEP_W  current step index.
- busy  out  1  high in RESTART, WAIT_DONE and ADVANCE.
- finished  out  1  one-cycle pulse when the last step completes.
- err  out  1  sticky watchdog error.

Behaviour:
- clrn low, asynchronous: state=IDLE, step=0, wdog=0, clr_cnt=0, busy=0, finished=0, err=0, cnt_clr=1.
- All outputs are decoded from registered state and registers only. There is no combinational input-to-output path.
- IDLE: cnt_clr=1, busy=0. If start=1, go to RESTART next cycle, with step=0, err=0 and clr_cnt=0.
- RESTART: cnt_clr=1, wdog=0. This state lasts exactly CLR_CYCLES cycles, then goes to WAIT_DONE.
- WAIT_DONE:
  - cnt_clr=0 and wdog increments every cycle.
  - cnt_done is ignored in the first WAIT_DONE cycle, which masks counter release latency.
  - From the second cycle on, cnt_done=1 moves to ADVANCE next cycle.
  - If wdog==TIMEOUT-1 and cnt_done=0, go to ERROR.
  - If cnt_done=1 and the timeout hit occur in the same cycle, done wins.
- ADVANCE: one cycle, cnt_clr=1.
  - If step==NUM_STEPS-1, go to FINISH.
  - Otherwise step increments and the state goes to RESTART.
  - step never wraps within a sequence.
- FINISH: one cycle, finished=1, cnt_clr=1, busy=0, then IDLE. step holds NUM_STEPS-1 until the next start.
- ERROR: err=1, cnt_clr=1, busy=0. The state holds until abort=1 (go to IDLE, err cleared) or reset. start is ignored in ERROR.
- abort=1 in any non-IDLE state: go to IDLE next cycle, step=0, err=0. abort beats done and timeout in the same cycle.
- start while busy is ignored; it is not queued.
- Latency per step = CLR_CYCLES + (cycles until cnt_done seen, >=2) + 1.
- Reset mid-sequence: immediate return to reset values. cnt_clr rises asynchronously with reset.

Optional Feature:
- Macro name: STEP_PAUSE_EN.
- When defined:
  - Adds input port pause (1 bit).
  - In WAIT_DONE with pause=1, wdog is frozen and cnt_done acceptance is deferred. The state stays WAIT_DONE, and the level-held cnt_done is accepted on the first cycle after pause falls.
  - pause has no effect in other states.
  - abort overrides pause.
- When undefined: no pause port; behaviour exactly as above.

Test Plan:
- Reset/idle: clrn=0 for 3 cycles, then 1, with start=0 -> cnt_clr=1, step=0, busy=0, err=0, finished=0.
- Full run: NUM_STEPS=3, CLR_CYCLES=2; counter model raises cnt_done 10 cycles after cnt_clr falls.
  - Pulse start for 1 cycle.
  - Required: cnt_clr low windows occur 3 times; step reads 0, 1, 2.
  - finished pulses exactly 1 cycle, 2+11+1 cycles after the 3rd RESTART entry; busy then falls.
- Timeout: TIMEOUT=20; model never raises cnt_done.
  - Required: err=1 exactly 20 cycles after entering WAIT_DONE; cnt_clr=1; err stays high for 50 cycles.
  - Then abort=1 for 1 cycle -> err=0, IDLE.
- Abort mid-run: abort during WAIT_DONE of step 1 -> next cycle IDLE, step=0, cnt_clr=1, no finished pulse.
  - A start pulse applied while busy during the run must not restart the sequence.
- Boundary: cnt_done already high in the first WAIT_DONE cycle -> ignored, ADVANCE on the 2nd cycle.
  - cnt_done rising on the same cycle as the timeout -> ADVANCE, err=0.
- STEP_PAUSE_EN:
  - pause=1 from WAIT_DONE entry for 30 cycles with TIMEOUT=20 and cnt_done=1 from cycle 10 -> no err, no advance.
  - pause falls -> ADVANCE on the following cycle.

Source files
------------

// File: rtl/step_sequence_ctrl.sv
// Step sequencer that restarts a non-recycling counter once per step.
// Optional STEP_PAUSE_EN adds a pause input that freezes the WAIT_DONE watchdog.
module step_sequence_ctrl #(
    parameter int NUM_STEPS  = 5,
    parameter int STEP_W     = 3,
    parameter int CLR_CYCLES = 2,
    parameter int TIMEOUT    = 200,
    parameter int WD_W       = 8
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              start,
    input  logic              abort,
    input  logic              cnt_done,
`ifdef STEP_PAUSE_EN
    input  logic              pause,
`endif
    output logic              cnt_clr,
    output logic [STEP_W-1:0] step,
    output logic              busy,
    output logic              finished,
    output logic              err
);

    localparam int CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESTART,
        S_WAIT,
        S_ADVANCE,
        S_FINISH,
        S_ERROR
    } state_t;

    state_t            state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [WD_W-1:0]   wdog_q, wdog_d;
    logic [CLR_W-1:0]  clr_cnt_q, clr_cnt_d;
    logic              first_q, first_d;

    logic paused;
    logic done_ok;
    logic wd_hit;
    logic last_step;
    logic clr_last;

`ifdef STEP_PAUSE_EN
    assign paused = pause;
`else
    assign paused = 1'b0;
`endif

    // The first WAIT_DONE cycle hides the counter's release latency.
    assign done_ok   = cnt_done && !first_q && !paused;
    assign wd_hit    = (wdog_q == WD_W'(TIMEOUT - 1)) && !paused;
    assign last_step = (step_q == STEP_W'(NUM_STEPS - 1));
    assign clr_last  = (clr_cnt_q == CLR_W'(CLR_CYCLES - 1));

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        wdog_d    = wdog_q;
        clr_cnt_d = clr_cnt_q;
        first_d   = first_q;

        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            step_d  = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start && !abort) begin
                        state_d   = S_RESTART;
                        step_d    = '0;
                        clr_cnt_d = '0;
                    end
                end
                S_RESTART: begin
                    wdog_d  = '0;
                    first_d = 1'b1;
                    if (clr_last) begin
                        state_d = S_WAIT;
                    end else begin
                        clr_cnt_d = clr_cnt_q + CLR_W'(1);
                    end
                end
                S_WAIT: begin
                    first_d = 1'b0;
                    if (!paused) begin
                        wdog_d = wdog_q + WD_W'(1);
                    end
                    // Done beats a simultaneous watchdog hit.
                    if (done_ok) begin
                        state_d = S_ADVANCE;
                    end else if (wd_hit) begin
                        state_d = S_ERROR;
                    end
                end
                S_ADVANCE: begin
                    if (last_step) begin
                        state_d = S_FINISH;
                    end else begin
                        step_d    = step_q + STEP_W'(1);
                        clr_cnt_d = '0;
                        state_d   = S_RESTART;
                    end
                end
                S_FINISH: begin
                    state_d = S_IDLE;
                end
                S_ERROR: begin
                    state_d = S_ERROR;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q   <= S_IDLE;
            step_q    <= '0;
            wdog_q    <= '0;
            clr_cnt_q <= '0;
            first_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            wdog_q    <= wdog_d;
            clr_cnt_q <= clr_cnt_d;
            first_q   <= first_d;
        end
    end

    assign cnt_clr  = (state_q != S_WAIT);
    assign step     = step_q;
    assign busy     = (state_q == S_RESTART) || (state_q == S_WAIT) ||
                      (state_q == S_ADVANCE);
    assign finished = (state_q == S_FINISH);
    assign err      = (state_q == S_ERROR);

endmodule

// File: tb/tb_step_sequence_ctrl.sv
// Scoreboard bench for step_sequence_ctrl with a cycle-timeline reference model.
// Build with +define+STEP_PAUSE_EN to exercise the pause input.
module tb_step_sequence_ctrl;

    localparam int N     = 3;
    localparam int SW    = 3;
    localparam int CLR   = 2;
    localparam int TO    = 20;
    localparam int WW    = 8;
    localparam int NEVER = 1000;

    localparam int K_CLR = 0;
    localparam int K_FIN = 1;
    localparam int K_ERR = 2;
    localparam int K_ABT = 3;

    logic          clk = 1'b0;
    logic          clrn = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          cnt_done = 1'b0;
`ifdef STEP_PAUSE_EN
    logic          pause = 1'b0;
`endif
    logic          cnt_clr;
    logic [SW-1:0] step;
    logic          busy;
    logic          finished;
    logic          err;

    step_sequence_ctrl #(
        .NUM_STEPS (N),
        .STEP_W    (SW),
        .CLR_CYCLES(CLR),
        .TIMEOUT   (TO),
        .WD_W      (WW)
    ) dut (
        .clk     (clk),
        .clrn    (clrn),
        .start   (start),
        .abort   (abort),
        .cnt_done(cnt_done),
`ifdef STEP_PAUSE_EN
        .pause   (pause),
`endif
        .cnt_clr (cnt_clr),
        .step    (step),
        .busy    (busy),
        .finished(finished),
        .err     (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int kind;
        int stp;
        int t;
    } ev_t;

    typedef struct {
        int         t;
        logic [5:0] v;
        bit         qe;
        string      nm;
    } chk_t;

    ev_t  exp_q[$];
    chk_t chk_q[$];
    int   ncmp = 0;
    int   nfail = 0;

    int cur_d[N];
    int cur_p[N];

    // Counter stand-in: done rises cur_d cycles after clear falls, held until clear.
    int lowc = 0;
    int dly;
    always @(negedge clk) begin
        dly = (int'(step) < N) ? cur_d[int'(step)] : NEVER;
        if (cnt_clr) lowc = 0;
        else lowc = lowc + 1;
        cnt_done = !cnt_clr && (lowc >= dly + 1);
    end

    task automatic got(input int kind, input int stp, input int now);
        ev_t e;
        ncmp++;
        if (exp_q.size() == 0) begin
            nfail++;
            $display("FAIL event: got kind=%0d step=%0d cycle=%0d, required none",
                     kind, stp, now);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.stp != stp || e.t != now) begin
                nfail++;
                $display("FAIL event: got kind=%0d step=%0d cycle=%0d, required kind=%0d step=%0d cycle=%0d",
                         kind, stp, now, e.kind, e.stp, e.t);
            end
        end
    endtask

    logic       prev_clr = 1'b1;
    logic       prev_err = 1'b0;
    chk_t       c;
    logic [5:0] act;
    always @(negedge clk) begin
        if (clrn) begin
            if (prev_clr && !cnt_clr) got(K_CLR, int'(step), cyc);
            if (finished) got(K_FIN, int'(step), cyc);
            if (err && !prev_err) got(K_ERR, int'(step), cyc);
            prev_clr = cnt_clr;
            prev_err = err;
        end else begin
            prev_clr = 1'b1;
            prev_err = 1'b0;
        end
        while (chk_q.size() > 0 && chk_q[0].t <= cyc) begin
            c   = chk_q.pop_front();
            act = {cnt_clr, busy, step, err};
            ncmp++;
            if (c.t != cyc || act != c.v) begin
                nfail++;
                $display("FAIL %s @%0d: clr/busy/step/err got %b, required %b (at %0d)",
                         c.nm, cyc, act, c.v, c.t);
            end
            if (c.qe) begin
                ncmp++;
                if (exp_q.size() != 0) begin
                    nfail++;
                    $display("FAIL %s_events: got %0d pending, required 0", c.nm, exp_q.size());
                    exp_q.delete();
                end
            end
        end
    end

    task automatic push_chk(input int t, input logic cl, input logic bs, input int st,
                            input logic er, input bit qe, input string nm);
        chk_t k;
        k.t  = t;
        k.v  = {cl, bs, st[SW-1:0], er};
        k.qe = qe;
        k.nm = nm;
        chk_q.push_back(k);
    endtask

    function automatic int max3(input int a, input int b, input int d);
        int m;
        m = (a > b) ? a : b;
        return (m > d) ? m : d;
    endfunction

    // Timeline model: per step, RESTART lasts CLR cycles; done is accepted at
    // wait offset max(delay, pause, 1); the watchdog counts only unpaused cycles.
    task automatic run_seq(input int a_off, input int hold, input bit xstart);
        ev_t evs[$];
        ev_t e;
`ifdef STEP_PAUSE_EN
        bit  pz[512];
`endif
        int  s, t, w, j, endt, ek, xs, a, kerr;
        s = cyc; t = s + 1; endt = s + 1; ek = K_FIN; xs = s + 4; a = -1; kerr = 0;
`ifdef STEP_PAUSE_EN
        for (int i = 0; i < 512; i++) pz[i] = 1'b0;
`endif
        for (int k = 0; k < N; k++) begin
            w = t + CLR;
            e.kind = K_CLR; e.stp = k; e.t = w;
            evs.push_back(e);
            if (k == 0) xs = w + 1;
`ifdef STEP_PAUSE_EN
            for (int i = 0; i < cur_p[k]; i++) pz[w + i - s] = 1'b1;
`endif
            j = max3(cur_d[k], cur_p[k], 1);
            if (j - cur_p[k] <= TO - 1) begin
                t = w + j + 2;
                if (k == N - 1) begin
                    e.kind = K_FIN; e.stp = k; e.t = t;
                    evs.push_back(e);
                    endt = t + 1;
                end
            end else begin
                e.kind = K_ERR; e.stp = k; e.t = w + cur_p[k] + TO;
                evs.push_back(e);
                endt = e.t; ek = K_ERR; kerr = k;
                break;
            end
        end
        if (a_off >= 0) begin
            a = s + 1 + a_off;
            if (a > endt - 1) a = endt - 1;
            endt = a + 1;
            ek = K_ABT;
        end
        foreach (evs[i]) if (a < 0 || evs[i].t <= a) exp_q.push_back(evs[i]);
        case (ek)
            K_FIN: push_chk(endt, 1'b1, 1'b0, N - 1, 1'b0, 1'b1, "finish_idle");
            K_ABT: push_chk(endt, 1'b1, 1'b0, 0, 1'b0, 1'b1, "abort_idle");
            default: begin
                for (int i = 0; i < hold; i++)
                    push_chk(endt + i, 1'b1, 1'b0, kerr, 1'b1, (i == hold - 1), "err_hold");
                push_chk(endt + hold + 1, 1'b1, 1'b0, 0, 1'b0, 1'b1, "err_abort_idle");
            end
        endcase
        for (int cc = s; cc < endt; cc++) begin
            start = (cc == s) || (xstart && cc == xs && (a < 0 || cc < a));
`ifdef STEP_PAUSE_EN
            pause = pz[cc - s];
`endif
            abort = (cc == a);
            @(negedge clk);
        end
        start = 1'b0;
        abort = 1'b0;
`ifdef STEP_PAUSE_EN
        pause = 1'b0;
`endif
        if (ek == K_ERR) begin
            repeat (hold) @(negedge clk);
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic set3(input int d0, input int d1, input int d2);
        cur_d[0] = d0; cur_d[1] = d1; cur_d[2] = d2;
        foreach (cur_p[i]) cur_p[i] = 0;
    endtask

    int s0;
    initial begin
        set3(NEVER, NEVER, NEVER);
        for (int t = 1; t <= 4; t++) push_chk(t, 1'b1, 1'b0, 0, 1'b0, 1'b0, "reset");
        repeat (3) @(negedge clk);
        clrn = 1'b1;
        repeat (3) @(negedge clk);

        set3(10, 10, 10);
        run_seq(-1, 0, 1'b1);
        set3(5, NEVER, 0);
        run_seq(-1, 50, 1'b0);
        set3(10, 10, 10);
        run_seq(19, 0, 1'b1);
        set3(0, 19, 20);
        run_seq(-1, 3, 1'b0);
        set3(0, 0, 1);
        run_seq(-1, 0, 1'b0);
`ifdef STEP_PAUSE_EN
        set3(10, 2, 3);
        cur_p[0] = 30; cur_p[2] = 5;
        run_seq(-1, 0, 1'b0);
        set3(NEVER, 0, 0);
        cur_p[0] = 4;
        run_seq(-1, 2, 1'b0);
`endif

        for (int r = 0; r < 40; r++) begin
            for (int k = 0; k < N; k++) begin
                cur_d[k] = ($urandom_range(0, 7) == 0) ? NEVER : int'($urandom_range(0, 22));
                cur_p[k] = 0;
`ifdef STEP_PAUSE_EN
                if ($urandom_range(0, 1) == 1) cur_p[k] = int'($urandom_range(0, 25));
`endif
            end
            run_seq(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 60)) : -1,
                    int'($urandom_range(1, 5)), 1'($urandom_range(0, 1)));
        end

        set3(10, 10, 10);
        s0 = cyc;
        begin
            ev_t e;
            e.kind = K_CLR; e.stp = 0; e.t = s0 + 3;
            exp_q.push_back(e);
        end
        push_chk(s0 + 9, 1'b1, 1'b0, 0, 1'b0, 1'b1, "async_reset");
        push_chk(s0 + 10, 1'b1, 1'b0, 0, 1'b0, 1'b1, "after_reset");
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        @(posedge clk);
        #2 clrn = 1'b0;
        @(negedge clk);
        #1 clrn = 1'b1;
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
